// File: rtl/inst_mem_loader_if.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_if
//
// Purpose: bundles the two busy paths of the boot loader. One is the byte
// stream from the UART receiver, a valid/ready handshake. The other is the
// instruction-RAM write port.
//
// Signals:
//   byte_valid  source has a byte on byte_data
//   byte_data   stream byte (8 bits)
//   byte_ready  loader accepts byte_data this cycle
//   mem_we      one-cycle instruction-RAM write strobe
//   mem_addr    write address (ADDR_W bits)
//   mem_data    write data (DATA_W bits)
//
// Modports:
//   master  the loader: consumes the stream and drives the RAM port
//   slave   the environment: produces the stream and observes the RAM port
// ---------------------------------------------------------------------------
interface inst_mem_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  // Loader side: it takes stream bytes in and owns the RAM write port.
  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_data
  );

  // Environment side: the UART byte source plus the instruction RAM.
  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );

endinterface

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Purpose: boot-time writer for the CPU's 16-bit instruction memory.
// A byte stream arrives from the UART receiver in this order:
//   count_lo, count_hi, then count x (word_lo, word_hi)
// The loader assembles each pair of bytes into a little-endian word. It writes
// the words one after another into instruction RAM, starting at BASE_ADDR.
// The CPU is held in stall while the image is loading. The stall is released
// only when the image is complete. After an error the CPU stays stalled, so
// it never runs a partial image.
//
// Optional feature: define INST_MEM_LOADER_CHECKSUM_EN to add a trailing
// checksum byte. That byte must equal the XOR of all count and data bytes.
// A mismatch ends the load in the error state.
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   start_i         one-cycle pulse that begins a load (only from idle/done/error)
//   bus             inst_mem_loader_if.master: byte stream in, RAM write out
//   cpu_stall_o     holds the CPU fetch/PC while loading
//   done_o          one-cycle pulse when a load completes successfully
//   err_o           sticky error flag, cleared by start or reset
//   words_loaded_o  number of words written in the current load
// ---------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [15:0]       MAX_WORDS = 16'h0100
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  inst_mem_loader_if.master  bus,
  output logic               cpu_stall_o,
  output logic               done_o,
  output logic               err_o,
  output logic [ADDR_W-1:0]  words_loaded_o
);

  // The word count always arrives as 16 bits. The comparison width covers
  // both that count and the word counter, even when ADDR_W is not 16.
  localparam int CMP_W = (ADDR_W > 16) ? ADDR_W : 16;

  typedef enum logic [3:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DAT_LO,
    DAT_HI,
    WRITE,
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERROR
  } state_e;

  state_e            state_q;
  logic [15:0]       count_q;
  logic [7:0]        wordLo_q;
  logic              byteReady_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memData_q;
  logic              cpuStall_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] wordsLoaded_q;

  logic              byteFire;
  logic              startAccept;
  logic [15:0]       countFull_d;
  logic [ADDR_W-1:0] wordsLoaded_d;
  logic              lastWord;
  logic [DATA_W-1:0] memData_d;

  // Helper terms for the FSM.
  // - A byte transfers only when the source offers one while we are ready.
  // - A start request is honoured only from the idle, done and error states.
  // - While the high count byte is being received, the full count is formed
  //   from that live byte. The valid/error decision is taken on the same edge.
  // - lastWord compares the counter after it increments, so the final WRITE
  //   cycle already knows that it is the last one.
  assign byteFire      = bus.byte_valid & byteReady_q;
  assign startAccept   = start_i & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERROR));
  assign countFull_d   = {bus.byte_data, count_q[7:0]};
  assign wordsLoaded_d = wordsLoaded_q + ADDR_W'(1);
  assign lastWord      = (CMP_W'(wordsLoaded_d) == CMP_W'(count_q));
  assign memData_d     = DATA_W'({bus.byte_data, wordLo_q});

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] chkXor_q;

  // Running XOR of every count and data byte in the current load. It is
  // cleared whenever a load starts. The checksum byte itself is not folded in,
  // because it is the value that gets compared against this register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chkXor_q <= '0;
    end else if (startAccept) begin
      chkXor_q <= '0;
    end else if (byteFire && (state_q != CHK)) begin
      chkXor_q <= chkXor_q ^ bus.byte_data;
    end
  end
`endif

  // Main loader FSM. All outputs are registered here.
  // - mem_we and done are single-cycle strobes. Each defaults low every cycle
  //   and is raised only on the edge that enters WRITE or DONE.
  // - byte_ready is raised on the edge that enters a receive state. It is
  //   dropped on the edge that leaves the receive states.
  // - On the way out of WRITE, the address and the word counter advance
  //   together, wrapping modulo 2^ADDR_W. The next word therefore lands at
  //   BASE_ADDR + words_loaded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wordLo_q      <= '0;
      byteReady_q   <= 1'b0;
      memWe_q       <= 1'b0;
      memAddr_q     <= BASE_ADDR;
      memData_q     <= '0;
      cpuStall_q    <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wordsLoaded_q <= '0;
    end else begin
      memWe_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (startAccept) begin
            state_q       <= CNT_LO;
            byteReady_q   <= 1'b1;
            cpuStall_q    <= 1'b1;
            err_q         <= 1'b0;
            wordsLoaded_q <= '0;
            memAddr_q     <= BASE_ADDR;
          end
        end
        CNT_LO: begin
          if (byteFire) begin
            count_q[7:0] <= bus.byte_data;
            state_q      <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (byteFire) begin
            count_q[15:8] <= bus.byte_data;
            if (countFull_d == 16'h0000) begin
              state_q     <= DONE;
              byteReady_q <= 1'b0;
              done_q      <= 1'b1;
              cpuStall_q  <= 1'b0;
            end else if (countFull_d > MAX_WORDS) begin
              state_q     <= ERROR;
              byteReady_q <= 1'b0;
              err_q       <= 1'b1;
            end else begin
              state_q <= DAT_LO;
            end
          end
        end
        DAT_LO: begin
          if (byteFire) begin
            wordLo_q <= bus.byte_data;
            state_q  <= DAT_HI;
          end
        end
        DAT_HI: begin
          if (byteFire) begin
            memData_q   <= memData_d;
            memWe_q     <= 1'b1;
            byteReady_q <= 1'b0;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          wordsLoaded_q <= wordsLoaded_d;
          memAddr_q     <= memAddr_q + ADDR_W'(1);
          if (lastWord) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            state_q     <= CHK;
            byteReady_q <= 1'b1;
`else
            state_q     <= DONE;
            done_q      <= 1'b1;
            cpuStall_q  <= 1'b0;
`endif
          end else begin
            state_q     <= DAT_LO;
            byteReady_q <= 1'b1;
          end
        end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (byteFire) begin
            byteReady_q <= 1'b0;
            if (bus.byte_data == chkXor_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpuStall_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          byteReady_q <= 1'b0;
          cpuStall_q  <= 1'b0;
        end
      endcase
    end
  end

  // Drive the outputs straight from the state registers.
  assign bus.byte_ready = byteReady_q;
  assign bus.mem_we     = memWe_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_data   = memData_q;
  assign cpu_stall_o    = cpuStall_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = wordsLoaded_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Bench for the instruction memory boot loader. It uses the default
// parameters: BASE_ADDR 0x0000 and MAX_WORDS 0x0100. With
// INST_MEM_LOADER_CHECKSUM_EN defined, every stream that should complete also
// carries its checksum byte, and the extra checksum cases are run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_mem_loader;

  localparam int          ADDR_W = 16;
  localparam int          DATA_W = 16;
  localparam logic [15:0] BASE   = 16'h0000;
  localparam int          MAXW   = 256;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic              cpu_stall_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W-1:0] words_loaded_o;

  inst_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_mem_loader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BASE_ADDR(BASE),
    .MAX_WORDS(16'h0100)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .bus           (bus),
    .cpu_stall_o   (cpu_stall_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .words_loaded_o(words_loaded_o)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed RAM writes and done pulses, collected on the falling edge.
  int          cycle       = 0;
  int          doneCount   = 0;
  int          doneCycle   = 0;
  int          lastWeCycle = 0;
  logic [15:0] wrAddrQ[$];
  logic [15:0] wrDataQ[$];

  // Expected results for the stream currently in stim, filled in by modelLoad.
  logic [7:0]  stim[$];
  logic [15:0] expAddrQ[$];
  logic [15:0] expDataQ[$];
  int          expErr;
  int          expDone;
  int          expWords;
  int          loadDoneBase;

  typedef struct {
    string       name;
    int          nBytes;
    logic [63:0] bytes;
    int          expWrites;
    int          expErr;
    int          expWords;
    logic [15:0] expLastData;
  } vec_t;

  vec_t vecs[6];

  // Monitor. mem_we and done are one-cycle strobes, so sampling each one once
  // per falling edge sees every strobe exactly once.
  always @(negedge clk) begin
    cycle++;
    if (bus.mem_we === 1'b1) begin
      wrAddrQ.push_back(bus.mem_addr);
      wrDataQ.push_back(bus.mem_data);
      lastWeCycle = cycle;
    end
    if (done_o === 1'b1) begin
      doneCount++;
      doneCycle = cycle;
    end
  end

  // Global time limit, in case a wait was somehow left unbounded.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at 2 ms, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the value the bench expects.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Pulse reset to bring the DUT back to a known state after a timeout.
  task automatic recover();
    bus.byte_valid = 1'b0;
    start_i        = 1'b0;
    rst_ni         = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  // Raise start for one cycle. Returns at the falling edge where it drops.
  task automatic pulseStart();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Offer one byte and hold it until byte_ready is seen (bounded). The
  // transfer happens on the rising edge inside the final wait.
  task automatic sendByte(input logic [7:0] b, output bit ok);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.byte_ready === 1'b1);
    if (ok) @(negedge clk);
    bus.byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL byte_timeout: byte_ready=0 after 50 cycles, required 1");
    end
  endtask

  // Reference model, working from the stream format alone:
  // - the first two bytes give the word count;
  // - count 0 completes with no writes;
  // - a count above MAX_WORDS is an error;
  // - otherwise word i is (hi << 8 | lo) and is written at BASE + i.
  task automatic modelLoad();
    int         cnt;
    logic [7:0] x;
    expAddrQ.delete();
    expDataQ.delete();
    expErr   = 0;
    expDone  = 0;
    expWords = 0;
    cnt = {16'h0, stim[1], stim[0]};
    if (cnt == 0) begin
      expDone = 1;
    end else if (cnt > MAXW) begin
      expErr = 1;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        expAddrQ.push_back(16'(BASE + 16'(i)));
        expDataQ.push_back({stim[3 + 2*i], stim[2 + 2*i]});
      end
      expWords = cnt;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int i = 0; i < 2 + 2*cnt; i++) x = x ^ stim[i];
      if (x == stim[2 + 2*cnt]) expDone = 1;
      else expErr = 1;
`else
      x = 8'h00;
      expDone = (x == 8'h00) ? 1 : 0;
`endif
    end
  endtask

  // With the checksum build, a stream that should complete also needs its
  // checksum byte. Without the checksum feature this task does nothing.
  task automatic appendChecksum();
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    int         cnt;
    logic [7:0] x;
    cnt = {16'h0, stim[1], stim[0]};
    if (cnt >= 1 && cnt <= MAXW) begin
      x = 8'h00;
      foreach (stim[i]) x = x ^ stim[i];
      stim.push_back(x);
    end
`endif
  endtask

  // Run one complete load of stim:
  // - start, then send every byte with idle gaps of gapMin..gapMax cycles;
  // - optionally raise start again while the load is busy;
  // - optionally check byte_ready during the gaps;
  // - then wait (bounded) for done or err.
  task automatic applyStimulus(input int gapMin, input int gapMax, input bit busyStart, input bit checkGap);
    bit ok;
    int n;
    int g;
    wrAddrQ.delete();
    wrDataQ.delete();
    loadDoneBase = doneCount;
    pulseStart();
    for (int i = 0; i < stim.size(); i++) begin
      if (busyStart && i == 2) start_i = 1'b1;
      sendByte(stim[i], ok);
      start_i = 1'b0;
      if (!ok) begin
        recover();
        return;
      end
      if (i != stim.size() - 1) begin
        g = int'($urandom_range(gapMax, gapMin));
        for (int k = 0; k < g; k++) begin
          if (checkGap && !(i >= 3 && (i % 2) == 1 && k == 0))
            checkOutput($sformatf("ready_in_gap b%0d c%0d", i, k), 32'(bus.byte_ready), 32'd1);
          @(negedge clk);
        end
      end
    end
    #1;
    n = 0;
    while (doneCount == loadDoneBase && err_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("[TB] FAIL completion_timeout: no done or err within 20 cycles, required one of them");
      recover();
      return;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Compare the finished load against the reference model.
  task automatic verifyLoad(input string name);
    int n;
    checkOutput({name, " write_count"}, 32'(wrAddrQ.size()), 32'(expAddrQ.size()));
    n = (wrAddrQ.size() < expAddrQ.size()) ? wrAddrQ.size() : expAddrQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s w%0d_addr", name, i), 32'(wrAddrQ[i]), 32'(expAddrQ[i]));
      checkOutput($sformatf("%s w%0d_data", name, i), 32'(wrDataQ[i]), 32'(expDataQ[i]));
    end
    checkOutput({name, " done_pulses"}, 32'(doneCount - loadDoneBase), 32'(expDone));
    checkOutput({name, " err"}, 32'(err_o), 32'(expErr));
    checkOutput({name, " cpu_stall"}, 32'(cpu_stall_o), 32'(expErr));
    checkOutput({name, " words_loaded"}, 32'(words_loaded_o), 32'(expWords));
    checkOutput({name, " byte_ready_idle"}, 32'(bus.byte_ready), 32'd0);
`ifndef INST_MEM_LOADER_CHECKSUM_EN
    if (expAddrQ.size() > 0 && expDone == 1 && wrAddrQ.size() > 0)
      checkOutput({name, " done_latency"}, 32'(doneCycle - lastWeCycle), 32'd1);
`endif
  endtask

  // Main test sequence.
  initial begin
    bit         ok;
    logic [15:0] cnt;
    int         sel;

    // Stream bytes are packed low byte first. For example,
    // 02 00 01 69 02 6A is 64'h0000_6A02_6901_0002.
    vecs[0] = '{"two_words",   6, 64'h0000_6A02_6901_0002, 2, 0, 2, 16'h6A02};
    vecs[1] = '{"zero_count",  2, 64'h0000_0000_0000_0000, 0, 0, 0, 16'h0000};
    vecs[2] = '{"over_max",    2, 64'h0000_0000_0000_0101, 0, 1, 0, 16'h0000};
    vecs[3] = '{"one_word",    4, 64'h0000_0000_004C_0001, 1, 0, 1, 16'h004C};
    vecs[4] = '{"three_words", 8, 64'h6655_4433_2211_0003, 3, 0, 3, 16'h6655};
    vecs[5] = '{"count_ffff",  2, 64'h0000_0000_0000_FFFF, 0, 1, 0, 16'h0000};

    rst_ni         = 1'b1;
    start_i        = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #1 rst_ni = 1'b0;
    #2;
    checkOutput("reset byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("reset mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'(BASE));
    checkOutput("reset mem_data", 32'(bus.mem_data), 32'd0);
    checkOutput("reset cpu_stall", 32'(cpu_stall_o), 32'd0);
    checkOutput("reset done", 32'(done_o), 32'd0);
    checkOutput("reset err", 32'(err_o), 32'd0);
    checkOutput("reset words_loaded", 32'(words_loaded_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Table vectors. Each one is checked against its own constants and
    // against the reference model.
    for (int v = 0; v < 6; v++) begin
      stim.delete();
      for (int k = 0; k < vecs[v].nBytes; k++) stim.push_back(vecs[v].bytes[8*k +: 8]);
      appendChecksum();
      modelLoad();
      applyStimulus(0, 1, 1'b0, 1'b0);
      checkOutput({vecs[v].name, " tbl_writes"}, 32'(wrAddrQ.size()), 32'(vecs[v].expWrites));
      checkOutput({vecs[v].name, " tbl_err"}, 32'(err_o), 32'(vecs[v].expErr));
      checkOutput({vecs[v].name, " tbl_words"}, 32'(words_loaded_o), 32'(vecs[v].expWords));
      if (vecs[v].expWrites > 0 && wrDataQ.size() > 0)
        checkOutput({vecs[v].name, " tbl_last_data"}, 32'(wrDataQ[wrDataQ.size()-1]), 32'(vecs[v].expLastData));
      verifyLoad(vecs[v].name);
    end

    // Source stalls: five idle cycles between bytes. The loader should wait
    // with byte_ready high and produce exactly one write.
    stim.delete();
    stim.push_back(8'h01); stim.push_back(8'h00); stim.push_back(8'h4C); stim.push_back(8'h00);
    appendChecksum();
    modelLoad();
    applyStimulus(5, 5, 1'b0, 1'b1);
    verifyLoad("gap5");

    // A start pulse in the middle of a load must be ignored.
    stim.delete();
    stim.push_back(8'h02); stim.push_back(8'h00); stim.push_back(8'h01);
    stim.push_back(8'h69); stim.push_back(8'h02); stim.push_back(8'h6A);
    appendChecksum();
    modelLoad();
    applyStimulus(0, 2, 1'b1, 1'b0);
    verifyLoad("busy_start");

    // Error case, then a restart that must clear err while keeping the CPU stalled.
    stim.delete();
    stim.push_back(8'h01); stim.push_back(8'h01);
    modelLoad();
    applyStimulus(0, 0, 1'b0, 1'b0);
    verifyLoad("err_then_start");
    pulseStart();
    #1;
    checkOutput("restart err_cleared", 32'(err_o), 32'd0);
    checkOutput("restart cpu_stall", 32'(cpu_stall_o), 32'd1);
    checkOutput("restart byte_ready", 32'(bus.byte_ready), 32'd1);
    sendByte(8'h00, ok);
    sendByte(8'h00, ok);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("restart zero cpu_stall", 32'(cpu_stall_o), 32'd0);
    checkOutput("restart zero err", 32'(err_o), 32'd0);

    // Reset arriving mid-word, after word_lo, between clock edges.
    pulseStart();
    sendByte(8'h02, ok);
    sendByte(8'h00, ok);
    sendByte(8'hAA, ok);
    checkOutput("pre_reset cpu_stall", 32'(cpu_stall_o), 32'd1);
    checkOutput("pre_reset byte_ready", 32'(bus.byte_ready), 32'd1);
    #3 rst_ni = 1'b0;
    #1;
    checkOutput("midreset byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("midreset mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("midreset cpu_stall", 32'(cpu_stall_o), 32'd0);
    checkOutput("midreset mem_addr", 32'(bus.mem_addr), 32'(BASE));
    checkOutput("midreset words", 32'(words_loaded_o), 32'd0);
    checkOutput("midreset err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    stim.delete();
    stim.push_back(8'h01); stim.push_back(8'h00); stim.push_back(8'h34); stim.push_back(8'h12);
    appendChecksum();
    modelLoad();
    applyStimulus(0, 1, 1'b0, 1'b0);
    verifyLoad("after_reset");

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    // Checksum of 01 00 00 08 is 09. The last byte decides success or error.
    stim.delete();
    stim.push_back(8'h01); stim.push_back(8'h00); stim.push_back(8'h00);
    stim.push_back(8'h08); stim.push_back(8'h09);
    modelLoad();
    applyStimulus(0, 1, 1'b0, 1'b0);
    verifyLoad("chk_good");
    checkOutput("chk_good err_const", 32'(err_o), 32'd0);
    stim[4] = 8'h08;
    modelLoad();
    applyStimulus(0, 1, 1'b0, 1'b0);
    verifyLoad("chk_bad");
    checkOutput("chk_bad err_const", 32'(err_o), 32'd1);
`endif

    // Randomized loads. The first one uses the largest accepted count.
    for (int r = 0; r < 12; r++) begin
      stim.delete();
      sel = int'($urandom_range(9, 0));
      if (r == 0)        cnt = 16'(MAXW);
      else if (sel == 0) cnt = 16'h0000;
      else if (sel == 1) cnt = 16'($urandom_range(65535, MAXW + 1));
      else               cnt = 16'($urandom_range(6, 1));
      stim.push_back(cnt[7:0]);
      stim.push_back(cnt[15:8]);
      if (int'(cnt) <= MAXW)
        for (int k = 0; k < 2 * int'(cnt); k++) stim.push_back(8'($urandom_range(255, 0)));
      appendChecksum();
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      if (cnt != 16'h0000 && int'(cnt) <= MAXW && $urandom_range(3, 0) == 0)
        stim[stim.size()-1] = stim[stim.size()-1] ^ 8'h5A;
`endif
      modelLoad();
      applyStimulus(0, 2, 1'b0, 1'b0);
      verifyLoad($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time writer for the CPU's 16-bit instruction memory, complementing the read-only instruction fetch path.
- Accepts a byte stream from a UART receiver over a valid/ready handshake and assembles little-endian 16-bit instruction words.
- Writes those words sequentially into instruction RAM starting at a base address.
- Holds the CPU in stall while loading and releases it when the image is complete.

Parameters:
- ADDR_W, 16, instruction address width (matches RegAddr)
- DATA_W, 16, instruction word width (matches RegValue); byte assembly requires 16
- BASE_ADDR, 16'h0000, address of the first written word
- MAX_WORDS, 16'h0100, largest accepted word count; larger counts raise err

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte_data this cycle
- mem_we  out  1  one-cycle instruction-RAM write strobe
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- cpu_stall  out  1  holds the CPU fetch/PC while loading
- done  out  1  one-cycle pulse when the load completes successfully
- err  out  1  sticky error flag, cleared by start or reset
- words_loaded  out  ADDR_W  count of words written in the current load

Behaviour:
- Reset (rst=0, async) values: state IDLE; byte_ready=0; mem_we=0; mem_addr=BASE_ADDR; mem_data=0; cpu_stall=0; done=0; err=0; words_loaded=0.
- Handshake:
  - A byte transfers on a rising edge where byte_valid & byte_ready are both 1.
  - byte_ready=1 only in CNT_LO, CNT_HI, DAT_LO, DAT_HI, and in CHK when the optional feature is enabled.
  - byte_ready is registered.
- Stream format: count_lo, count_hi, then count×(word_lo, word_hi).
- States and transitions:
  - IDLE: start → CNT_LO; err cleared, words_loaded cleared, mem_addr=BASE_ADDR, cpu_stall=1.
  - CNT_LO: byte → count[7:0]; go to CNT_HI.
  - CNT_HI: byte → count[15:8]. Then:
    - count==0 → DONE.
    - count>MAX_WORDS → ERROR.
    - otherwise → DAT_LO.
  - DAT_LO: byte → word[7:0]; go to DAT_HI.
  - DAT_HI: byte → word[15:8]; go to WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_data=word, mem_addr=BASE_ADDR+words_loaded.
    - Next cycle: words_loaded+1 and mem_addr+1, each wrapping modulo 2^ADDR_W.
    - If words_loaded+1==count → DONE (or CHK when the feature is enabled); else → DAT_LO.
  - DONE: done=1 for the single entry cycle; cpu_stall=0 from that cycle on; stays in DONE until start.
  - ERROR: err=1; cpu_stall stays 1 (the CPU must not run a partial image); stays in ERROR until start or reset.
- Latency: the last accepted byte's write occurs exactly 1 cycle later. A word costs a minimum of 3 cycles.
- Stalls: byte_valid low in any receive state holds the state indefinitely; no timeout.
- Simultaneous events:
  - start while busy (CNT_LO..WRITE/CHK) is ignored.
  - start in DONE or ERROR restarts the load and overrides other outputs that cycle.
- Reset mid-load: immediately abandons the load, drops mem_we and cpu_stall. RAM contents already written are not restored.

Optional Feature:
- Macro: INST_MEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the final WRITE, state CHK accepts one byte.
  - The expected byte is the XOR of all count and data bytes.
  - Match → DONE; mismatch → ERROR (err=1, cpu_stall held).
  - The running XOR resets on start.
- Disabled: no CHK state and no XOR register. After the last WRITE the loader goes straight to DONE, and any extra byte is not accepted (byte_ready=0).

Test Plan:
- Reset then start; stream 02 00 01 69 02 6A → writes 16'h6901 @0x0000 and 16'h6A02 @0x0001, one mem_we each; done pulses 1 cycle after the second write; cpu_stall returns to 0; words_loaded=2.
- Start; stream 00 00 → no mem_we; done in the cycle after CNT_HI; err=0.
- Start; stream 01 01 (count 0x0101 > MAX_WORDS 0x0100) → ERROR; err=1; cpu_stall=1; no writes. A following start clears err.
- Stream 01 00 4C 00 with byte_valid deasserted for 5 cycles between bytes → single write 16'h004C @0x0000; byte_ready stays high while waiting; no spurious mem_we.
- Assert rst=0 mid-word (after word_lo) → outputs at reset values asynchronously. Start after release begins a fresh load at BASE_ADDR.
- With INST_MEM_LOADER_CHECKSUM_EN, stream 01 00 00 08 09 → done. Checksum byte 0x08 instead → ERROR, err=1.
